// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the imem loader.
// slave is the loader's view; master is the view of the stream source and memory.
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Fills MIPS instruction memory from a length-prefixed, checksummed byte stream.
// The core is held in cpu_reset until a load completes with a good checksum.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    logic [2:0]      state;
    logic [2:0]      next_state;
    logic [7:0]      len_lo;
    logic [15:0]     n_words;
    logic [ADDR_W:0] word_cnt;
    logic [ADDR_W:0] cnt_inc;
    logic [1:0]      byte_idx;
    logic [23:0]     shreg;
    logic [7:0]      chk;
    logic            accept;
    logic [15:0]     n_hdr;
    logic            hdr_bad;
    logic            last_word;

    assign accept    = bus.in_valid && bus.in_ready;
    assign n_hdr     = {bus.in_data, len_lo};
    assign hdr_bad   = (n_hdr == 16'd0) || ({1'b0, n_hdr} > MAX_WORDS);
    assign cnt_inc   = word_cnt + 1'b1;
    assign last_word = (16'(cnt_inc) == n_words);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN_LO;
            S_LEN_LO: if (accept) next_state = S_LEN_HI;
            S_LEN_HI: if (accept) next_state = hdr_bad ? S_ERR : S_DATA;
            S_DATA:   if (accept && byte_idx == 2'd3) next_state = S_WRITE;
            S_WRITE:  next_state = last_word ? S_CHECK : S_DATA;
            S_CHECK:  if (accept) next_state = (bus.in_data == chk) ? S_DONE : S_ERR;
            default:  next_state = S_IDLE;
        endcase
    end

    // in_ready and mem_we are registered copies of the state being entered,
    // so they are valid for the whole cycle the FSM spends in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
            cpu_reset     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            len_lo        <= 8'd0;
            n_words       <= 16'd0;
            word_cnt      <= '0;
            byte_idx      <= 2'd0;
            shreg         <= 24'd0;
            chk           <= 8'd0;
        end else begin
            state        <= next_state;
            bus.in_ready <= (next_state == S_LEN_LO) || (next_state == S_LEN_HI) ||
                            (next_state == S_DATA)   || (next_state == S_CHECK);
            bus.mem_we   <= (next_state == S_WRITE);
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        cpu_reset <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        word_cnt  <= '0;
                        byte_idx  <= 2'd0;
                        chk       <= 8'd0;
                    end
                end
                S_LEN_LO: begin
                    if (accept) len_lo <= bus.in_data;
                end
                S_LEN_HI: begin
                    if (accept) begin
                        n_words <= n_hdr;
                        if (hdr_bad) begin
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shreg    <= {bus.in_data, shreg[23:8]};
                        chk      <= chk ^ bus.in_data;
                        byte_idx <= byte_idx + 2'd1;
                        // Earlier bytes sit little-endian in shreg; the 4th is the top byte.
                        if (byte_idx == 2'd3) begin
                            bus.mem_addr  <= word_cnt[ADDR_W-1:0];
                            bus.mem_wdata <= {bus.in_data, shreg};
                        end
                    end
                end
                S_WRITE: begin
                    word_cnt <= cnt_inc;
                    byte_idx <= 2'd0;
                end
                S_CHECK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (bus.in_data == chk) begin
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as streams are sent
// and a negedge monitor pops and compares every mem_we cycle.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_reset, busy, done, error;

    int  checks = 0;
    int  errors = 0;
    int  we_total = 0;
    int  we_mark = 0;
    bit  aborted = 1'b0;
    wr_t exp_q[$];

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus.slave),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            we_total++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write_addr", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                checkOutput("write_addr", 32'(bus.mem_addr), 32'(w.addr));
                checkOutput("write_data", bus.mem_wdata, w.data);
            end
        end
    end

    task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Present one byte from a negedge and return at the negedge after it is taken.
    task automatic applyStimulus(input logic [7:0] b, input bit gap);
        int cnt;
        if (aborted) return;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        cnt = 0;
        while (bus.in_ready !== 1'b1) begin
            @(negedge clk);
            cnt++;
            if (cnt > 100) begin
                checkOutput("handshake_timeout", 32'd0, 32'd1);
                aborted = 1'b1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input byte_q_t s, input bit gaps);
        foreach (s[i]) applyStimulus(s[i], gaps);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (busy === 1'b1) begin
            @(negedge clk);
            cnt++;
            if (cnt > 2000) begin
                checkOutput("busy_timeout", 32'd1, 32'd0);
                return;
            end
        end
    endtask

    task automatic check_final(input string tag, input logic d, input logic e, input int writes);
        checkOutput({tag, "_done"}, 32'(done), 32'(d));
        checkOutput({tag, "_error"}, 32'(error), 32'(e));
        checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!d));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        checkOutput({tag, "_we_cycles"}, 32'(we_total - we_mark), 32'(writes));
        checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        byte_q_t s;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Two words, no gaps; CHK = 13^20^08 = 3B.
        we_mark = we_total;
        expect_write(8'h00, 32'h2000_0013);
        expect_write(8'h01, 32'h0000_0008);
        pulse_start();
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00, 8'h00, 8'h3B};
        send_stream(s, 1'b0);
        wait_idle();
        check_final("t1", 1'b1, 1'b0, 2);

        // Same stream with a bubble before every byte; restart from DONE re-asserts cpu_reset.
        we_mark = we_total;
        expect_write(8'h00, 32'h2000_0013);
        expect_write(8'h01, 32'h0000_0008);
        pulse_start();
        checkOutput("t2_restart_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("t2_restart_busy", 32'(busy), 32'd1);
        checkOutput("t2_restart_done", 32'(done), 32'd0);
        send_stream(s, 1'b1);
        wait_idle();
        check_final("t2", 1'b1, 1'b0, 2);

        // Bad checksum: writes still happen, then error.
        we_mark = we_total;
        expect_write(8'h00, 32'h2000_0013);
        expect_write(8'h01, 32'h0000_0008);
        pulse_start();
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00, 8'h00, 8'h3A};
        send_stream(s, 1'b0);
        wait_idle();
        check_final("t3", 1'b0, 1'b1, 2);

        // Zero-length header fails right after LEN_HI.
        we_mark = we_total;
        pulse_start();
        s = '{8'h00, 8'h00};
        send_stream(s, 1'b0);
        check_final("t4_zero", 1'b0, 1'b1, 0);

        // N = 257 exceeds a 256-word memory.
        we_mark = we_total;
        pulse_start();
        s = '{8'h01, 8'h01};
        send_stream(s, 1'b0);
        check_final("t4_257", 1'b0, 1'b1, 0);

        // Full memory, word i = i; XOR of 0..255 is 00.
        we_mark = we_total;
        s = '{8'h00, 8'h01};
        for (int i = 0; i < 256; i++) begin
            s.push_back(8'(i));
            s.push_back(8'h00);
            s.push_back(8'h00);
            s.push_back(8'h00);
            expect_write(8'(i), 32'(i));
        end
        s.push_back(8'h00);
        pulse_start();
        send_stream(s, 1'b0);
        wait_idle();
        check_final("t5", 1'b1, 1'b0, 256);
        checkOutput("t5_last_addr", 32'(bus.mem_addr), 32'h0000_00FF);
        checkOutput("t5_last_data", bus.mem_wdata, 32'h0000_00FF);

        // Reset after 5 payload bytes, then a fresh 1-word load.
        we_mark = we_total;
        expect_write(8'h00, 32'h2000_0013);
        pulse_start();
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h08};
        send_stream(s, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_values("t6_midreset");
        checkOutput("t6_writes_before_reset", 32'(we_total - we_mark), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        we_mark = we_total;
        expect_write(8'h00, 32'hDEAD_BEEF);
        pulse_start();
        s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_stream(s, 1'b0);
        wait_idle();
        check_final("t6", 1'b1, 1'b0, 1);

        // A start pulse during a load is ignored.
        we_mark = we_total;
        expect_write(8'h00, 32'h2000_0013);
        expect_write(8'h01, 32'h0000_0008);
        pulse_start();
        s = '{8'h02, 8'h00, 8'h13, 8'h00};
        send_stream(s, 1'b0);
        pulse_start();
        checkOutput("t7_busy_after_start", 32'(busy), 32'd1);
        s = '{8'h00, 8'h20, 8'h08, 8'h00, 8'h00, 8'h00, 8'h3B};
        send_stream(s, 1'b0);
        wait_idle();
        check_final("t7", 1'b1, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
